// File: rtl/wta_lif_array.sv
// Array of leaky integrate-and-fire neurons with winner-take-all lateral inhibition.
// Exactly one channel (the largest candidate, lowest index on ties) may spike per enabled edge.
module wta_lif_array #(
    parameter int N          = 4,
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N*W-1:0]         current,
    input  logic [W-1:0]           threshold,
    input  logic [W-1:0]           inhibit,
    output logic [N-1:0]           spike,
    output logic [$clog2(N)-1:0]   winner_idx,
    output logic                   winner_valid,
    output logic [N*W-1:0]         state
);
    localparam int IW = $clog2(N);
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    logic [N-1:0][W-1:0]  state_r;
    logic [N-1:0][RW-1:0] cnt_r;
    logic [N-1:0]         spike_r;
    logic [IW-1:0]        idx_r;
    logic                 valid_r;

    logic [N-1:0][W-1:0]  nxt_s;
    logic [N-1:0][W-1:0]  state_nxt_s;
    logic [N-1:0][RW-1:0] cnt_nxt_s;
    logic [N-1:0]         refr_s;
    logic [N-1:0]         cand_s;
    logic [N-1:0]         spike_nxt_s;
    logic                 found_s;
    logic [IW-1:0]        win_idx_s;
    logic [W-1:0]         win_val_s;

    // Saturate a W+1 bit sum back into W bits.
    function automatic logic [W-1:0] sat_w(input logic [W:0] v);
        if (v[W]) begin
            sat_w = {W{1'b1}};
        end else begin
            sat_w = v[W-1:0];
        end
    endfunction

    // Leaky integration and candidate qualification per channel.
    always_comb begin
        nxt_s  = '0;
        refr_s = '0;
        cand_s = '0;
        for (int i = 0; i < N; i++) begin
            nxt_s[i]  = sat_w({1'b0, state_r[i]} - {1'b0, (state_r[i] >> LEAK_SHIFT)}
                              + {1'b0, current[i*W +: W]});
            refr_s[i] = (cnt_r[i] != {RW{1'b0}});
            cand_s[i] = !refr_s[i] && (threshold != {W{1'b0}}) && (nxt_s[i] >= threshold);
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        found_s   = 1'b0;
        win_idx_s = '0;
        win_val_s = '0;
        for (int i = 0; i < N; i++) begin
            if (cand_s[i] && (!found_s || (nxt_s[i] > win_val_s))) begin
                found_s   = 1'b1;
                win_idx_s = IW'(i);
                win_val_s = nxt_s[i];
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Next membrane state, refractory count and spike vector.
    always_comb begin
        state_nxt_s = '0;
        cnt_nxt_s   = '0;
        spike_nxt_s = '0;
        for (int i = 0; i < N; i++) begin
            if (refr_s[i]) begin
                state_nxt_s[i] = {W{1'b0}};
                cnt_nxt_s[i]   = cnt_r[i] - RW'(1);
            end else if (found_s && (win_idx_s == IW'(i))) begin
                state_nxt_s[i] = {W{1'b0}};
                cnt_nxt_s[i]   = RW'(REFRAC);
                spike_nxt_s[i] = 1'b1;
            end else if (found_s) begin
                state_nxt_s[i] = (nxt_s[i] > inhibit) ? (nxt_s[i] - inhibit) : {W{1'b0}};
                cnt_nxt_s[i]   = {RW{1'b0}};
            end else begin
                state_nxt_s[i] = nxt_s[i];
                cnt_nxt_s[i]   = {RW{1'b0}};
            end
        end
    end

    // State registers; a disabled edge freezes everything but clears the spike pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= '0;
            cnt_r   <= '0;
            spike_r <= '0;
            idx_r   <= '0;
            valid_r <= 1'b0;
        end else if (en) begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            spike_r <= spike_nxt_s;
            idx_r   <= found_s ? win_idx_s : idx_r;
            valid_r <= found_s;
        end else begin
            spike_r <= '0;
            valid_r <= 1'b0;
        end
    end

    assign state        = state_r;
    assign spike        = spike_r;
    assign winner_idx   = idx_r;
    assign winner_valid = valid_r;

endmodule

// File: tb/tb_wta_lif_array.sv
// Directed self-checking bench for wta_lif_array (N=4, W=8, LEAK_SHIFT=1, REFRAC=2).
module tb_wta_lif_array;
    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] current;
    logic [7:0]  threshold;
    logic [7:0]  inhibit;
    logic [3:0]  spike;
    logic [1:0]  winner_idx;
    logic        winner_valid;
    logic [31:0] state;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    wta_lif_array #(.N(4), .W(8), .LEAK_SHIFT(1), .REFRAC(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .current      (current),
        .threshold    (threshold),
        .inhibit      (inhibit),
        .spike        (spike),
        .winner_idx   (winner_idx),
        .winner_valid (winner_valid),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges, then check that everything cleared at once.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_rst_state"}, state, 32'd0);
        chk({tag, "_rst_spike"}, {28'd0, spike}, 32'd0);
        chk({tag, "_rst_valid"}, {31'd0, winner_valid}, 32'd0);
        chk({tag, "_rst_idx"}, {30'd0, winner_idx}, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        current   = 32'd0;
        threshold = 8'd0;
        inhibit   = 8'd0;

        // Reset held with random inputs
        for (int k = 0; k < 3; k++) begin
            current   = $urandom;
            threshold = 8'($urandom_range(1, 255));
            inhibit   = 8'($urandom_range(0, 255));
            tick();
            chk("hold_rst_state", state, 32'd0);
            chk("hold_rst_spike", {28'd0, spike, winner_valid, winner_idx}, 32'd0);
        end
        rst = 1'b0;

        // Single channel accumulates 60, 90, then spikes at 105
        current = {8'd0, 8'd0, 8'd0, 8'd60}; threshold = 8'd100; inhibit = 8'd0;
        tick(); chk("acc_e1", state, 32'd60);     chk("acc_e1_spk", {28'd0, spike}, 32'd0);
        tick(); chk("acc_e2", state, 32'd90);
        tick(); chk("acc_e3_spk", {28'd0, spike}, 32'd1);
        chk("acc_e3_valid", {31'd0, winner_valid}, 32'd1);
        chk("acc_e3_idx", {30'd0, winner_idx}, 32'd0);
        chk("acc_e3_state", state, 32'd0);
        tick(); chk("refr_e4", state, 32'd0);     chk("refr_e4_spk", {28'd0, spike, winner_valid}, 32'd0);
        tick(); chk("refr_e5", state, 32'd0);
        tick(); chk("refr_e6", state, 32'd60);

        // Pause mid-accumulation: 60 held for 5 edges then 90, 105-spike
        pulse_reset("p1");
        tick(); chk("pause_pre", state, 32'd60);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(); chk("pause_hold", state, 32'd60); chk("pause_spk", {28'd0, spike, winner_valid}, 32'd0);
        end
        en = 1'b1;
        tick(); chk("pause_res1", state, 32'd90);
        tick(); chk("pause_res2_spk", {28'd0, spike}, 32'd1);
        // Pause during refractory: counter must not drain while disabled
        en = 1'b0;
        tick(); chk("pause_r_spk", {28'd0, spike, winner_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick(); chk("pause_r_hold", state, 32'd0);
        end
        chk("pause_r_idx", {30'd0, winner_idx}, 32'd0);
        en = 1'b1;
        tick(); chk("pause_r_e1", state, 32'd0);
        tick(); chk("pause_r_e2", state, 32'd0);
        tick(); chk("pause_r_e3", state, 32'd60);

        // Mid-refractory async reset discards the pending period
        current = {8'd0, 8'd0, 8'd0, 8'd100};
        tick(); chk("mid_spk", {28'd0, spike}, 32'd1);
        pulse_reset("p2");
        current = {8'd0, 8'd0, 8'd0, 8'd60};
        tick(); chk("post_rst", state, 32'd60);

        // Tie between channels 1 and 2 goes to channel 1; loser inhibited
        pulse_reset("p3");
        current = {8'd0, 8'd120, 8'd120, 8'd0}; threshold = 8'd100; inhibit = 8'd50;
        tick();
        chk("tie_spk", {28'd0, spike}, 32'd2);
        chk("tie_idx", {30'd0, winner_idx}, 32'd1);
        chk("tie_valid", {31'd0, winner_valid}, 32'd1);
        chk("tie_state", state, {8'd0, 8'd70, 8'd0, 8'd0});

        // Largest candidate wins over lower index
        pulse_reset("p4");
        current = {8'd200, 8'd0, 8'd0, 8'd150}; threshold = 8'd100; inhibit = 8'd50;
        tick();
        chk("big_spk", {28'd0, spike}, 32'd8);
        chk("big_idx", {30'd0, winner_idx}, 32'd3);
        chk("big_state", state, {8'd0, 8'd0, 8'd0, 8'd100});

        // Threshold 0 disables spiking; membrane saturates at 255
        pulse_reset("p5");
        current = {8'd0, 8'd0, 8'd0, 8'd200}; threshold = 8'd0; inhibit = 8'd0;
        tick(); chk("sat_e1", state, 32'd200);
        current = {8'd0, 8'd0, 8'd0, 8'd255};
        for (int k = 0; k < 4; k++) begin
            tick(); chk("sat_state", state, 32'd255); chk("sat_spk", {28'd0, spike, winner_valid}, 32'd0);
        end

        // Full inhibition clamps losers at 0; refractory winner ignores its current
        pulse_reset("p6");
        current = {8'd30, 8'd40, 8'd150, 8'd10}; threshold = 8'd100; inhibit = 8'd255;
        tick();
        chk("inh_spk", {28'd0, spike}, 32'd2);
        chk("inh_state", state, 32'd0);
        tick();
        chk("inh2_spk", {28'd0, spike, winner_valid}, 32'd0);
        chk("inh2_idx", {30'd0, winner_idx}, 32'd1);
        chk("inh2_state", state, {8'd30, 8'd40, 8'd0, 8'd10});

        // Equal-to-threshold is a candidate
        pulse_reset("p7");
        current = {8'd0, 8'd0, 8'd0, 8'd100}; threshold = 8'd100; inhibit = 8'd0;
        tick(); chk("eq_spk", {28'd0, spike}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/wta_lif_array.md
WTA_LIF_ARRAY -- requirements
Module: wta_lif_array

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of LIF neuron channels (2..16).
REQ-002 SHALL have parameter W, default 8, meaning membrane state and input width in bits.
REQ-003 SHALL have parameter LEAK_SHIFT, default 1, meaning the leak term is state >> LEAK_SHIFT.
REQ-004 SHALL have parameter REFRAC, default 2, meaning refractory cycles after a spike (0 allowed).
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-007 SHALL have port en, input, 1 bit, meaning update enable.
REQ-008 SHALL have port current, input, N*W bits, meaning the per-channel input current; channel i is at bits [i*W +: W].
REQ-009 SHALL have port threshold, input, W bits, meaning the spike threshold; a value of 0 disables spiking.
REQ-010 SHALL have port inhibit, input, W bits, meaning the lateral inhibition subtracted from losers.
REQ-011 SHALL have port spike, output, N bits, meaning a registered one-hot-or-zero spike vector.
REQ-012 SHALL have port winner_idx, output, clog2(N) bits, meaning the index of the most recent winner.
REQ-013 SHALL have port winner_valid, output, 1 bit, meaning a registered pulse that is high in any cycle where spike is nonzero.
REQ-014 SHALL have port state, output, N*W bits, meaning the registered membrane potentials, packed the same way as current.

Function
REQ-015 SHALL, for each channel per enabled edge, compute nxt_i = state_i - (state_i >> LEAK_SHIFT) + current_i in at least W+1 bits, saturating at 2^W-1.
REQ-016 SHALL hold a channel with a nonzero refractory counter at state 0, decrement its counter, exclude it from competition, and ignore its current.
REQ-017 SHALL treat a non-refractory channel with nxt_i >= threshold (and threshold != 0) as a candidate.
REQ-018 SHALL select as winner the candidate with the largest nxt_i; ties go to the lowest index.
REQ-019 SHALL, when a winner exists, set spike to the one-hot winner bit, load winner_idx, pulse winner_valid, set the winner's state to 0, and load its refractory counter with REFRAC.
REQ-020 SHALL, when a winner exists, set every other non-refractory channel's state to nxt_i - inhibit, saturating at 0.
REQ-021 SHALL, when no winner exists, set state_i = nxt_i for non-refractory channels, with spike = 0 and winner_valid = 0, and hold winner_idx.
REQ-022 SHALL have a latency of exactly one edge: current sampled at edge k is reflected in state/spike after edge k.
REQ-023 SHALL, when en = 0, freeze state, refractory counters and winner_idx, and drive spike = 0 and winner_valid = 0 after the next edge.
REQ-024 SHALL, with REFRAC = 0, make the winner eligible on the very next enabled edge.
REQ-025 SHALL allow at most one spike bit set in any cycle.

Reset
REQ-026 SHALL, while rst is high and regardless of clk, clear state, spike, winner_idx, winner_valid and all refractory counters to 0.
REQ-027 SHALL, when rst is asserted mid-operation, discard pending refractory periods, and SHALL evaluate the first enabled edge after rst deasserts from all-zero state.

Verification (N=4, W=8, LEAK_SHIFT=1, REFRAC=2)
REQ-028 SHALL be tested with rst held high and random inputs -> all outputs are 0; async assertion between edges clears outputs immediately.
REQ-029 SHALL be tested with current0=60, others 0, threshold=100, en=1 -> state0 goes 60, 90, then spike=0001, winner_idx=0, state0=0 on the 3rd edge; state0 stays 0 for 2 edges, then reads 60.
REQ-030 SHALL be tested with current1=current2=120, threshold=100, inhibit=50 from reset -> on the 1st edge spike=0010, winner_idx=1, state1=0, state2=70.
REQ-031 SHALL be tested with state0=200, current0=255, threshold=0 -> state0 saturates at 255 and spike stays 0 indefinitely.
REQ-032 SHALL be tested with en deasserted for 5 cycles mid-accumulation -> state and refractory counts are unchanged, spike=0, and accumulation resumes identically afterward.
REQ-033 SHALL be tested with inhibit=255 and a winner present -> all non-refractory losers read 0 and no underflow wraps.
